alu_seq_core: RTL and testbench

//  Parametrised sequential ALU core: successor of the two-counter/combinational-mux datapath.

---
 rtl/alu_seq_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core
// Sequential ALU core. Keeps NUM_CH up/down operand counters driven by debounced
// switch levels, picks any two counters as operands, and runs one operation per
// start request. MUL (shift-add) and DIV (restoring) iterate for WIDTH cycles;
// all other ops complete in one cycle. The result is held on a valid/ready handshake.
//
// Ports
//   clk_i        system clock
//   reset_i      asynchronous reset, active-high
//   up_i/down_i  debounced up/down levels, one bit per counter
//   sel_a_i/b_i  operand counter indices (out-of-range index reads as 0)
//   op_i         operation code
//   start_i      start request level, sampled each clock
//   busy_o       operation in progress
//   res_valid_o  result_o/flags_o valid
//   res_ready_i  consumer accepts the result
//   result_o     2*WIDTH result
//   flags_o      {divzero, carry/borrow, zero}
//   count_o      all counter values, channel 0 in the LSBs
module alu_seq_core #(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 2,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_CH-1:0]           up_i,
  input  logic [NUM_CH-1:0]           down_i,
  input  logic [$clog2(NUM_CH)-1:0]   sel_a_i,
  input  logic [$clog2(NUM_CH)-1:0]   sel_b_i,
  input  logic [2:0]                  op_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [2*WIDTH-1:0]          result_o,
  output logic [2:0]                  flags_o,
  output logic [NUM_CH*WIDTH-1:0]     count_o
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  logic [NUM_CH-1:0][WIDTH-1:0] count_q, count_d;
  logic [NUM_CH-1:0]            up_prev_q, down_prev_q, up_rise, down_rise;
  state_t                       state_q, state_d;
  logic [WIDTH-1:0]             a_q, a_d, b_q, b_d, mplier_q, mplier_d;
  logic [2:0]                   op_q, op_d, flags_q, flags_d;
  logic [2*WIDTH-1:0]           acc_q, acc_d, mcand_q, mcand_d, result_q, result_d;
  logic [CW-1:0]                iter_q, iter_d;
  logic                         busy_q, busy_d, valid_q, valid_d;

  logic [WIDTH-1:0]   opnd_a, opnd_b, div_rem;
  logic [WIDTH:0]     sum_w, diff_w, div_top;
  logic               div_ge, iterative, launch;
  logic [2*WIDTH-1:0] mul_next, div_next, iter_next, single_res;
  logic               single_carry, single_divzero;

  function automatic logic [WIDTH-1:0] count_up(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] sum;
    sum = {1'b0, v} + (WIDTH+1)'(STEP);
    if (SATURATE != 0 && sum[WIDTH]) return '1;
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] count_down(input logic [WIDTH-1:0] v);
    if (SATURATE != 0 && v < WIDTH'(STEP)) return '0;
    return v - WIDTH'(STEP);
  endfunction

  assign up_rise   = up_i & ~up_prev_q;
  assign down_rise = down_i & ~down_prev_q;

  // Counter update: a rising edge on exactly one of up/down moves the counter;
  // simultaneous edges cancel and a held level never re-counts.
  always_comb begin
    count_d = count_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (up_rise[k] && !down_rise[k]) count_d[k] = count_up(count_q[k]);
      else if (down_rise[k] && !up_rise[k]) count_d[k] = count_down(count_q[k]);
    end
  end

  // Operand selection; indices with no matching counter leave the operand at 0.
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_a_i == SEL_W'(k)) opnd_a = count_q[k];
      if (sel_b_i == SEL_W'(k)) opnd_b = count_q[k];
    end
  end

  // One iteration of shift-add multiply and restoring divide. For DIV, acc holds
  // {remainder, quotient}; the pair shifts left and the new quotient bit enters at bit 0.
  always_comb begin
    sum_w     = {1'b0, a_q} + {1'b0, b_q};
    diff_w    = {1'b0, a_q} - {1'b0, b_q};
    mul_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    div_top   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_top >= {1'b0, b_q});
    div_rem   = div_ge ? (div_top[WIDTH-1:0] - b_q) : div_top[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    iter_next = (op_q == OP_MUL) ? mul_next : div_next;
    iterative = (op_q == OP_MUL) || (op_q == OP_DIV && b_q != '0);
  end

  // Single-cycle results, including the divide-by-zero shortcut.
  always_comb begin
    single_res     = {{WIDTH{1'b0}}, a_q};
    single_carry   = 1'b0;
    single_divzero = 1'b0;
    case (op_q)
      OP_ADD: begin
        single_res   = {{(WIDTH-1){1'b0}}, sum_w};
        single_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        single_res   = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
        single_carry = diff_w[WIDTH];
      end
      OP_DIV: begin
        single_res     = {a_q, {WIDTH{1'b1}}};
        single_divzero = 1'b1;
      end
      OP_AND:  single_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   single_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  single_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      default: single_res = {{WIDTH{1'b0}}, a_q};
    endcase
  end

  // Start is honoured in IDLE and DONE; in DONE it wins over ready and discards the result.
  assign launch = start_i && (state_q != S_EXEC);

  // Control FSM next state; operands are captured at launch so counter
  // movement during EXEC cannot disturb a running operation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    if (launch) begin
      a_d      = opnd_a;
      b_d      = opnd_b;
      op_d     = op_i;
      acc_d    = (op_i == OP_MUL) ? '0 : {{WIDTH{1'b0}}, opnd_a};
      mcand_d  = {{WIDTH{1'b0}}, opnd_a};
      mplier_d = opnd_b;
      iter_d   = '0;
      busy_d   = 1'b1;
      valid_d  = 1'b0;
      state_d  = S_EXEC;
    end else begin
      case (state_q)
        S_EXEC: begin
          if (iterative) begin
            acc_d    = iter_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            iter_d   = iter_q + 1'b1;
            if (iter_q == CW'(WIDTH-1)) begin
              result_d = iter_next;
              flags_d  = {2'b00, iter_next == '0};
              busy_d   = 1'b0;
              valid_d  = 1'b1;
              state_d  = S_DONE;
            end
          end else begin
            result_d = single_res;
            flags_d  = {single_divzero, single_carry, single_res == '0};
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready_i) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All state registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q     <= '0;
      up_prev_q   <= '0;
      down_prev_q <= '0;
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      iter_q      <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      up_prev_q   <= up_i;
      down_prev_q <= down_i;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      iter_q      <= iter_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign res_valid_o = valid_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core
// Directed bench for alu_seq_core. A wrapping instance (dut) covers counters,
// handshake, all op classes, start priority and asynchronous reset; a saturating
// instance (dut_sat) covers counter clamping. Expected values are hand-computed.
module tb_alu_seq_core;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  up_i, down_i;
  logic [0:0]  sel_a_i, sel_b_i;
  logic [2:0]  op_i;
  logic        start_i, res_ready_i;
  logic        busy_o, res_valid_o;
  logic [15:0] result_o;
  logic [2:0]  flags_o;
  logic [15:0] count_o;

  logic [1:0]  up_s, down_s;
  logic [0:0]  sel_s;
  logic [2:0]  op_s;
  logic        start_s, ready_s;
  logic        busy_s, valid_s;
  logic [15:0] result_s;
  logic [2:0]  flags_s;
  logic [15:0] count_s;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  alu_seq_core #(.WIDTH(8), .NUM_CH(2), .STEP(1), .SATURATE(0)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i),
    .sel_a_i(sel_a_i), .sel_b_i(sel_b_i), .op_i(op_i), .start_i(start_i),
    .busy_o(busy_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .result_o(result_o), .flags_o(flags_o), .count_o(count_o)
  );

  alu_seq_core #(.WIDTH(8), .NUM_CH(2), .STEP(1), .SATURATE(1)) dut_sat (
    .clk_i(clk_i), .reset_i(reset_i), .up_i(up_s), .down_i(down_s),
    .sel_a_i(sel_s), .sel_b_i(sel_s), .op_i(op_s), .start_i(start_s),
    .busy_o(busy_s), .res_valid_o(valid_s), .res_ready_i(ready_s),
    .result_o(result_s), .flags_o(flags_s), .count_o(count_s)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic stepClk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyReset();
    reset_i = 1'b1;
    up_i = '0; down_i = '0; up_s = '0; down_s = '0;
    start_i = 1'b0; res_ready_i = 1'b0;
    repeat (2) stepClk();
    reset_i = 1'b0;
    stepClk();
  endtask

  // n single-cycle pulses on the masked channels of either instance.
  task automatic pulse(input logic [1:0] mask, input bit isUp, input bit sat, input int n);
    for (int i = 0; i < n; i++) begin
      if (sat) begin
        if (isUp) up_s = mask; else down_s = mask;
      end else begin
        if (isUp) up_i = mask; else down_i = mask;
      end
      stepClk();
      up_i = '0; down_i = '0; up_s = '0; down_s = '0;
      stepClk();
    end
  endtask

  // Launch one op, count busy cycles, then check result and flags.
  // With disturb set, start and a counter edge are injected mid-operation.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic sa,
                               input logic sb, input int expBusy, input logic [15:0] expRes,
                               input logic [2:0] expFlags, input bit disturb);
    int cycles;
    sel_a_i = sa; sel_b_i = sb; op_i = op;
    start_i = 1'b1;
    stepClk();
    start_i = 1'b0;
    cycles = 0;
    while (busy_o === 1'b1 && cycles < 100) begin
      if (disturb && cycles == 2) begin
        start_i = 1'b1; up_i[0] = 1'b1;
      end else if (disturb && cycles == 3) begin
        start_i = 1'b0; up_i[0] = 1'b0;
      end
      cycles++;
      stepClk();
    end
    start_i = 1'b0; up_i = '0;
    checkOutput({tag, "_busycycles"}, cycles, expBusy);
    checkOutput({tag, "_valid"}, res_valid_o, 1);
    checkOutput({tag, "_result"}, result_o, expRes);
    checkOutput({tag, "_flags"}, flags_o, expFlags);
  endtask

  // Result must hold while ready is low and drop the cycle after ready is seen.
  task automatic releaseResult(input string tag, input logic [15:0] expRes);
    res_ready_i = 1'b0;
    repeat (2) stepClk();
    checkOutput({tag, "_hold_valid"}, res_valid_o, 1);
    checkOutput({tag, "_hold_result"}, result_o, expRes);
    res_ready_i = 1'b1;
    stepClk();
    res_ready_i = 1'b0;
    checkOutput({tag, "_drop_valid"}, res_valid_o, 0);
    checkOutput({tag, "_drop_busy"}, busy_o, 0);
  endtask

  initial begin
    sel_s = '0; op_s = '0; start_s = 1'b0; ready_s = 1'b0;
    sel_a_i = '0; sel_b_i = '0; op_i = '0;

    // Reset state and counter edge behaviour
    applyReset();
    checkOutput("rst_count", count_o, 16'h0000);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_valid", res_valid_o, 0);
    checkOutput("rst_result", result_o, 16'h0000);
    checkOutput("rst_flags", flags_o, 3'b000);
    pulse(2'b01, 1'b1, 1'b0, 3);
    up_i[1] = 1'b1;
    repeat (50) stepClk();
    up_i[1] = 1'b0;
    stepClk();
    checkOutput("held_level", count_o, 16'h0103);
    up_i[1] = 1'b1; down_i[1] = 1'b1;
    stepClk();
    up_i = '0; down_i = '0;
    stepClk();
    checkOutput("both_edges", count_o, 16'h0103);

    // ADD 200+100 with handshake
    pulse(2'b01, 1'b1, 1'b0, 197);
    pulse(2'b10, 1'b1, 1'b0, 99);
    checkOutput("cnt_200_100", count_o, 16'h64C8);
    applyStimulus("add", 3'b000, 1'b0, 1'b1, 1, 16'd300, 3'b010, 1'b0);
    releaseResult("add", 16'd300);

    // SUB 5-7, PASS A with A=0
    applyReset();
    pulse(2'b11, 1'b1, 1'b0, 5);
    pulse(2'b10, 1'b1, 1'b0, 2);
    checkOutput("cnt_5_7", count_o, 16'h0705);
    applyStimulus("sub", 3'b001, 1'b0, 1'b1, 1, 16'hFFFE, 3'b010, 1'b0);
    releaseResult("sub", 16'hFFFE);
    pulse(2'b01, 1'b0, 1'b0, 5);
    applyStimulus("passa", 3'b111, 1'b0, 1'b1, 1, 16'h0000, 3'b001, 1'b0);
    releaseResult("passa", 16'h0000);

    // MUL 255*255 with mid-op start and counter change, wrap 0-1 -> 255
    applyReset();
    pulse(2'b11, 1'b0, 1'b0, 1);
    checkOutput("wrap_down", count_o, 16'hFFFF);
    applyStimulus("mul", 3'b010, 1'b0, 1'b1, 8, 16'hFE01, 3'b000, 1'b1);
    checkOutput("mul_cnt_moved", count_o, 16'hFF00);
    releaseResult("mul", 16'hFE01);

    // DIV 200/7, DIV 200/0, start priority over ready in DONE
    applyReset();
    pulse(2'b11, 1'b1, 1'b0, 7);
    pulse(2'b01, 1'b1, 1'b0, 193);
    checkOutput("cnt_200_7", count_o, 16'h07C8);
    applyStimulus("div", 3'b011, 1'b0, 1'b1, 8, 16'h041C, 3'b000, 1'b0);
    releaseResult("div", 16'h041C);
    pulse(2'b10, 1'b0, 1'b0, 7);
    applyStimulus("div0", 3'b011, 1'b0, 1'b1, 1, 16'hC8FF, 3'b100, 1'b0);
    start_i = 1'b1; res_ready_i = 1'b1;
    stepClk();
    start_i = 1'b0; res_ready_i = 1'b0;
    checkOutput("prio_busy", busy_o, 1);
    checkOutput("prio_valid", res_valid_o, 0);
    stepClk();
    checkOutput("prio_done_valid", res_valid_o, 1);
    checkOutput("prio_done_result", result_o, 16'hC8FF);
    releaseResult("div0", 16'hC8FF);

    // Saturating counters
    applyReset();
    pulse(2'b01, 1'b0, 1'b1, 1);
    checkOutput("sat_low", count_s, 16'h0000);
    pulse(2'b10, 1'b1, 1'b1, 256);
    checkOutput("sat_high", count_s, 16'hFF00);

    // Asynchronous reset in the middle of a MUL restarted from DONE
    pulse(2'b11, 1'b0, 1'b0, 1);
    applyStimulus("mul2", 3'b010, 1'b0, 1'b1, 8, 16'hFE01, 3'b000, 1'b0);
    start_i = 1'b1;
    stepClk();
    start_i = 1'b0;
    checkOutput("restart_busy", busy_o, 1);
    repeat (2) stepClk();
    #2 reset_i = 1'b1;
    #1;
    checkOutput("async_busy", busy_o, 0);
    checkOutput("async_valid", res_valid_o, 0);
    checkOutput("async_result", result_o, 16'h0000);
    checkOutput("async_count", count_o, 16'h0000);
    stepClk();
    reset_i = 1'b0;
    stepClk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
